// File: rtl/shaper_pkg.sv
// Shared state type, default parameters and saturation helper for the
// trapezoidal shaper and its peak detector.
package shaper_pkg;

    localparam int                 DEF_DATA_W  = 8;
    localparam int                 DEF_OUT_W   = 8;
    localparam int                 DEF_ACC_W   = 24;
    localparam int                 DEF_K       = 4;
    localparam int                 DEF_L       = 8;
    localparam logic signed [15:0] DEF_M       = 16'sd0;
    localparam int                 DEF_SHIFT   = 0;
    localparam int                 DEF_HOLDOFF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ABOVE,
        HOLD
    } peak_state_e;

    // Clamps a sign-extended value into the range of a signed word of the given width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Enable-gated shift register holding the most recent DEPTH accepted samples,
// with taps at TAP_K, TAP_L and DEPTH samples back.
module sample_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int TAP_K = 4,
    parameter int TAP_L = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] tap_k_o,
    output logic [WIDTH-1:0] tap_l_o,
    output logic [WIDTH-1:0] tap_kl_o
);

    logic [WIDTH-1:0] hist_q [DEPTH];

    // NOTE: the history is reset rather than left undefined because the filter
    // treats every sample before the first accepted one as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else if (en_i) begin
            hist_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    assign tap_k_o  = hist_q[TAP_K-1];
    assign tap_l_o  = hist_q[TAP_L-1];
    assign tap_kl_o = hist_q[DEPTH-1];

endmodule

// File: rtl/trap_shaper_pd.sv
// Trapezoidal shaper with pole-zero correction and output saturation, followed
// by a threshold peak detector reporting the maximum and width of each pulse.
module trap_shaper_pd
    import shaper_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 OUT_W   = DEF_OUT_W,
    parameter int                 ACC_W   = DEF_ACC_W,
    parameter int                 K       = DEF_K,
    parameter int                 L       = DEF_L,
    parameter logic signed [15:0] M       = DEF_M,
    parameter int                 SHIFT   = DEF_SHIFT,
    parameter int                 HOLDOFF = DEF_HOLDOFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [OUT_W-1:0]  threshold,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     peak_valid,
    output logic signed [OUT_W-1:0]  peak_value,
    output logic [15:0]              peak_width
);

    localparam logic signed [ACC_W-1:0] M_EXT     = ACC_W'(M);
    localparam logic [15:0]             HOLD_LAST = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);

    logic [DATA_W-1:0] tap_k, tap_l, tap_kl;

    sample_delay_line #(
        .WIDTH (DATA_W),
        .DEPTH (K + L),
        .TAP_K (K),
        .TAP_L (L)
    ) u_history (
        .clk      (clk),
        .rst      (rst),
        .en_i     (in_valid),
        .data_i   (in_data),
        .tap_k_o  (tap_k),
        .tap_l_o  (tap_l),
        .tap_kl_o (tap_kl)
    );

    logic signed [ACC_W-1:0] d_q, p_q, m_q, r_q, s_q;
    logic signed [ACC_W-1:0] d_d, p_d, m_d, r_d, s_d, shifted;
    logic signed [63:0]      y_wide;
    logic signed [OUT_W-1:0] y_q, y_d;
    logic                    sat_q, sat_d, out_valid_q;

    always_comb begin
        d_d     = ACC_W'(in_data) - ACC_W'($signed(tap_k))
                - ACC_W'($signed(tap_l)) + ACC_W'($signed(tap_kl));
        p_d     = p_q + d_q;
        m_d     = d_q * M_EXT;
        r_d     = p_q + m_q;
        s_d     = s_q + r_q;
        shifted = s_q >>> SHIFT;
        y_wide  = saturate(64'(shifted), OUT_W);
        y_d     = OUT_W'(y_wide);
        sat_d   = (y_wide != 64'(shifted));
    end

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // pre-edge value, which is what makes this a pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q         <= '0;
            p_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            s_q         <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                d_q   <= d_d;
                p_q   <= p_d;
                m_q   <= m_d;
                r_q   <= r_d;
                s_q   <= s_d;
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    peak_state_e             state_q;
    logic signed [OUT_W-1:0] max_q, peak_value_q;
    logic [15:0]             width_q, hold_cnt_q, peak_width_q;
    logic                    peak_valid_q;

    // The detector looks at the value being loaded into out_data, so a report
    // appears in the same cycle as the first sample at or below threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            max_q        <= '0;
            width_q      <= '0;
            hold_cnt_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_value_q <= '0;
            peak_width_q <= '0;
        end else begin
            peak_valid_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    IDLE: begin
                        if (y_d > threshold) begin
                            state_q <= ABOVE;
                            max_q   <= y_d;
                            width_q <= 16'd1;
                        end
                    end
                    ABOVE: begin
                        if (y_d > threshold) begin
                            if (y_d > max_q) max_q <= y_d;
                            if (width_q != 16'hFFFF) width_q <= width_q + 16'd1;
                        end else begin
                            state_q      <= HOLD;
                            hold_cnt_q   <= '0;
                            peak_valid_q <= 1'b1;
                            peak_value_q <= max_q;
                            peak_width_q <= width_q;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) state_q <= IDLE;
                        else                         hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = y_q;
    assign out_sat    = sat_q;
    assign peak_valid = peak_valid_q;
    assign peak_value = peak_value_q;
    assign peak_width = peak_width_q;

endmodule

// File: tb/tb_trap_shaper_pd.sv
// Randomized and directed bench for trap_shaper_pd against a sample-indexed
// reference model of the shaper equations and the pulse reporting rules.
module tb_trap_shaper_pd;

    localparam int                 DATA_W  = 8;
    localparam int                 OUT_W   = 8;
    localparam int                 ACC_W   = 24;
    localparam int                 K       = 4;
    localparam int                 L       = 8;
    localparam logic signed [15:0] M       = 16'sd0;
    localparam int                 SHIFT   = 0;
    localparam int                 HOLDOFF = 2;
    localparam int                 LAT     = 5;
    localparam int                 Y_MAX   = (1 << (OUT_W - 1)) - 1;
    localparam int                 Y_MIN   = -(1 << (OUT_W - 1));

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic signed [OUT_W-1:0]  threshold = '0;
    logic                     out_valid, out_sat, peak_valid;
    logic signed [OUT_W-1:0]  out_data, peak_value;
    logic [15:0]              peak_width;

    int n_cmp = 0;
    int n_bad = 0;

    trap_shaper_pd #(
        .DATA_W (DATA_W), .OUT_W (OUT_W), .ACC_W (ACC_W), .K (K), .L (L),
        .M (M), .SHIFT (SHIFT), .HOLDOFF (HOLDOFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .peak_valid (peak_valid),
        .peak_value (peak_value),
        .peak_width (peak_width)
    );

    always #5 clk = ~clk;

    // Reference model: accepted-sample history and per-sample results.
    int     xs[$];
    int     ys[$];
    bit     ysat[$];
    longint p_m, s_m;
    int     exp_out, exp_pval, exp_pwid;
    bit     exp_sat, exp_ov, exp_pv;
    bit     in_pulse;
    int     mx, wd, skip;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint span;
        span = longint'(1) <<< ACC_W;
        v = v & (span - 1);
        if (v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic int xh(input int k);
        return (k < 0) ? 0 : xs[k];
    endfunction

    task automatic model_reset();
        xs.delete(); ys.delete(); ysat.delete();
        p_m = 0; s_m = 0;
        exp_out = 0; exp_sat = 0; exp_ov = 0; exp_pv = 0; exp_pval = 0; exp_pwid = 0;
        in_pulse = 0; mx = 0; wd = 0; skip = 0;
    endtask

    task automatic model_accept(input int x, input int thr);
        int     n, yc;
        longint d, r, yf;
        n = xs.size();
        xs.push_back(x);
        d   = wrap_acc(longint'(xh(n) - xh(n - K) - xh(n - L) + xh(n - K - L)));
        p_m = wrap_acc(p_m + d);
        r   = wrap_acc(p_m + longint'(M) * d);
        s_m = wrap_acc(s_m + r);
        yf  = s_m >>> SHIFT;
        yc  = (yf > Y_MAX) ? Y_MAX : (yf < Y_MIN) ? Y_MIN : int'(yf);
        ys.push_back(yc);
        ysat.push_back(yf != longint'(yc));
        if (n >= LAT - 1) begin
            exp_out = ys[n - LAT + 1];
            exp_sat = ysat[n - LAT + 1];
        end else begin
            exp_out = 0;
            exp_sat = 0;
        end
        exp_pv = 0;
        if (skip > 0) begin
            skip--;
        end else if (in_pulse) begin
            if (exp_out > thr) begin
                if (exp_out > mx) mx = exp_out;
                if (wd < 65535) wd++;
            end else begin
                exp_pv   = 1;
                exp_pval = mx;
                exp_pwid = wd;
                in_pulse = 0;
                skip     = (HOLDOFF > 0) ? HOLDOFF : 1;
            end
        end else if (exp_out > thr) begin
            in_pulse = 1;
            mx       = exp_out;
            wd       = 1;
        end
    endtask

    task automatic compare_all();
        check("out_valid",  out_valid,  exp_ov);
        check("out_data",   out_data,   exp_out);
        check("out_sat",    out_sat,    exp_sat);
        check("peak_valid", peak_valid, exp_pv);
        check("peak_value", peak_value, exp_pval);
        check("peak_width", peak_width, exp_pwid);
    endtask

    task automatic step(input bit v, input int x, input int thr);
        in_valid  = v;
        in_data   = DATA_W'(x);
        threshold = OUT_W'(thr);
        @(posedge clk);
        #1;
        exp_ov = v;
        exp_pv = 0;
        if (v) model_accept(x, thr);
        compare_all();
    endtask

    // Single-sample pulse of height amp: the shaped output is amp times a
    // 1,2,3,4,4,4,4,4,3,2,1,0 trapezoid, clamped to the output range.
    task automatic run_pulse(input int amp, input int thr, input int gap,
                             output int reps, output int rep_val,
                             output int rep_wid, output int rep_out);
        int tri_w[12];
        int e;
        tri_w = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
        reps = 0; rep_val = 0; rep_wid = 0; rep_out = 0;
        for (int n = 0; n < 20; n++) begin
            step(1'b1, (n == 0) ? amp : 0, thr);
            if (peak_valid) begin
                reps++;
                rep_val = peak_value;
                rep_wid = peak_width;
                rep_out = out_data;
            end
            if (n >= LAT - 1 && n - LAT + 1 < 12) begin
                e = amp * tri_w[n - LAT + 1];
                check("pulse_out", out_data, (e > Y_MAX) ? Y_MAX : e);
                check("pulse_sat", out_sat, (e > Y_MAX) ? 1 : 0);
            end
            for (int g = 0; g < gap; g++) begin
                step(1'b0, int'($urandom_range(0, 255)) - 128, thr);
                if (peak_valid) reps++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int reps, rv, rw, ro, thr;
        int rep_w[2];
        int rep_v[2];

        // Reset state, checked asynchronously and across a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Unit pulse with threshold 25: one report at the out_data=20 sample.
        run_pulse(10, 25, 0, reps, rv, rw, ro);
        check("pulse_reports", reps, 1);
        check("pulse_peak_value", rv, 40);
        check("pulse_peak_width", rw, 7);
        check("pulse_report_out", ro, 20);

        // Large pulse: clamped plateau, threshold equal to the clamp never crossed.
        run_pulse(100, 127, 0, reps, rv, rw, ro);
        check("sat_reports", reps, 0);

        // Threshold boundary: equal is not above.
        run_pulse(10, 40, 0, reps, rv, rw, ro);
        check("thr_eq_reports", reps, 0);
        run_pulse(10, 39, 0, reps, rv, rw, ro);
        check("thr_below_reports", reps, 1);
        check("thr_below_width", rw, 5);
        check("thr_below_value", rv, 40);

        // Gapped input: same sequence on accepted samples.
        run_pulse(10, 25, 2, reps, rv, rw, ro);
        check("gap_reports", reps, 1);
        check("gap_peak_width", rw, 7);

        // Reset at the third output sample of a pulse discards it.
        for (int n = 0; n < 7; n++) step(1'b1, (n == 0) ? 10 : 0, 25);
        check("pre_reset_out", out_data, 30);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        reps = 0;
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 0, 25);
            if (peak_valid) reps++;
        end
        check("post_reset_reports", reps, 0);
        run_pulse(10, 25, 0, reps, rv, rw, ro);
        check("fresh_reports", reps, 1);
        check("fresh_peak_width", rw, 7);

        // Second crossing lands inside the holdoff window after the first report.
        reps = 0;
        rep_w = '{0, 0};
        rep_v = '{0, 0};
        for (int n = 0; n < 30; n++) begin
            step(1'b1, (n == 0) ? 10 : (n == 10) ? 60 : 0, 25);
            if (peak_valid) begin
                if (reps < 2) begin
                    rep_w[reps] = peak_width;
                    rep_v[reps] = peak_value;
                end
                reps++;
            end
        end
        check("holdoff_reports", reps, 2);
        check("holdoff_first_width", rep_w[0], 7);
        check("holdoff_first_value", rep_v[0], 40);
        check("holdoff_second_width", rep_w[1], 9);
        check("holdoff_second_value", rep_v[1], 127);

        // Randomized traffic against the reference model.
        thr = 20;
        for (int i = 0; i < 1500; i++) begin
            bit v;
            int x;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       x = int'($urandom_range(0, 255)) - 128;
                1, 2:    x = int'($urandom_range(5, 40));
                default: x = int'($urandom_range(0, 6)) - 3;
            endcase
            if ($urandom_range(0, 49) == 0) thr = int'($urandom_range(0, 80)) - 10;
            step(v, x, thr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
